// File: rtl/mem_port_arbiter.sv
// Arbitrates the single AXI-bridge memory port between instruction fetch and load/store.
// One transaction at a time; attributes are registered at grant and held until the bridge answers.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT  = 4,
    parameter bit CONFREG_REMAP = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [1:0]  d_size,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        stall_req,
    output logic        mem_access,
    output logic        mem_write,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_sel,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_st_data,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, INST, DATA, DRAIN} state_t;

    localparam int            CW    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    state_t        state, state_nxt;
    logic [CW-1:0] starve_cnt, starve_nxt;
    logic          grant_i, grant_d;
    logic [31:0]   d_addr_mapped;

    // The confreg window is reached through its physical alias; fetches are never remapped.
    assign d_addr_mapped = (CONFREG_REMAP && d_addr[31:16] == 16'hbfaf)
                         ? {16'h1faf, d_addr[15:0]} : d_addr;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!flush) begin
                    if (d_req && !(i_req && starve_cnt == LIMIT)) begin
                        grant_d   = 1'b1;
                        state_nxt = DATA;
                    end else if (i_req) begin
                        grant_i   = 1'b1;
                        state_nxt = INST;
                    end
                end
            end
            INST, DATA: begin
                if (mem_ready)  state_nxt = IDLE;
                else if (flush) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (mem_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Fetch fairness: counts data grants that overtook a waiting fetch.
    always_comb begin
        starve_nxt = starve_cnt;
        if (state == IDLE) begin
            if (grant_i)
                starve_nxt = '0;
            else if (grant_d && i_req)
                starve_nxt = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 1'b1;
            else if (!i_req)
                starve_nxt = '0;
        end
    end

    always_comb begin
        i_ready   = (state == INST) && mem_ready && !flush;
        d_ready   = (state == DATA) && mem_ready && !flush;
        i_rdata   = mem_rdata;
        d_rdata   = mem_rdata;
        stall_req = (state == DRAIN) || (i_req && !i_ready) || (d_req && !d_ready);
    end

    // Attributes stay at their last value after completion; only mem_access drops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_access  <= 1'b0;
            mem_write   <= 1'b0;
            mem_size    <= 2'b00;
            mem_sel     <= 4'b0000;
            mem_addr    <= 32'h0;
            mem_st_data <= 32'h0;
        end else if (grant_i) begin
            mem_access  <= 1'b1;
            mem_write   <= 1'b0;
            mem_size    <= 2'b10;
            mem_sel     <= 4'b1111;
            mem_addr    <= i_addr;
            mem_st_data <= 32'h0;
        end else if (grant_d) begin
            mem_access  <= 1'b1;
            mem_write   <= d_write;
            mem_size    <= d_size;
            mem_sel     <= d_sel;
            mem_addr    <= d_addr_mapped;
            mem_st_data <= d_wdata;
        end else if (state != IDLE && mem_ready) begin
            mem_access  <= 1'b0;
        end
    end

endmodule
